// File: rtl/ps2_rx_core.sv
// ps2_rx_core: PS/2 device-to-host receiver.
// The two pad lines are synchronised and deglitched. The receiver then deframes
// 11-bit frames and checks odd parity and the stop bit. Good scan codes are
// buffered in a first-word-fall-through FIFO.
// Ports:
//   clk_i, rst_i          system clock, asynchronous active-high reset
//   en_i                  receiver enable (low holds the deframer idle; FIFO kept)
//   ps2_clk_i, ps2_dat_i  raw asynchronous PS/2 lines
//   rd_i, clr_i           pop head entry / flush FIFO and clear overflow
//   dat_o, vld_o, cnt_o   FIFO head byte (0 when empty), non-empty flag, occupancy
//   par_err_o, frm_err_o  one-cycle pulses for dropped frames
//   ovf_o, irq_o          sticky overflow, interrupt (vld_o | ovf_o)
module ps2_rx_core #(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned FILT_LEN    = 4,
    parameter int unsigned TIMEOUT_CYC = 2400
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        en_i,
    input  logic                        ps2_clk_i,
    input  logic                        ps2_dat_i,
    input  logic                        rd_i,
    input  logic                        clr_i,
    output logic [7:0]                  dat_o,
    output logic                        vld_o,
    output logic [$clog2(FIFO_DEPTH):0] cnt_o,
    output logic                        par_err_o,
    output logic                        frm_err_o,
    output logic                        ovf_o,
    output logic                        irq_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned FW = $clog2(FILT_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    // Line conditioning: index 0 = PS/2 clock, index 1 = PS/2 data
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    filt;
    logic [FW-1:0] fcnt [2];
    logic          clk_q;
    logic          fall_c;
    logic          bit_c;

    // Two-flop synchroniser followed by a run-length filter per line
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1   <= 2'b11;
            sync2   <= 2'b11;
            filt    <= 2'b11;
            fcnt[0] <= '0;
            fcnt[1] <= '0;
            clk_q   <= 1'b1;
        end else begin
            sync1 <= {ps2_dat_i, ps2_clk_i};
            sync2 <= sync1;
            clk_q <= filt[0];
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == FW'(FILT_LEN - 1)) begin
                    filt[i] <= sync2[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + FW'(1);
                end
            end
        end
    end

    assign fall_c = clk_q & ~filt[0];
    assign bit_c  = filt[1];

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PAR, S_STOP} state_t;

    state_t        state, state_nx;
    logic [7:0]    shreg, shreg_nx;
    logic [2:0]    bcnt, bcnt_nx;
    logic          par_q, par_nx;
    logic [TW-1:0] tmo, tmo_nx;
    logic          perr_nx, ferr_nx;
    logic          push_c;

    // Deframer next-state; tmo counts cycles since the last fall while mid-frame
    always_comb begin
        state_nx = state;
        shreg_nx = shreg;
        bcnt_nx  = bcnt;
        par_nx   = par_q;
        tmo_nx   = tmo;
        perr_nx  = 1'b0;
        ferr_nx  = 1'b0;
        push_c   = 1'b0;
        if (!en_i) begin
            state_nx = S_IDLE;
            tmo_nx   = '0;
        end else if (state == S_IDLE) begin
            tmo_nx = '0;
            if (fall_c && !bit_c) begin
                state_nx = S_DATA;
                bcnt_nx  = 3'd0;
                tmo_nx   = TW'(1);
            end
        end else if (fall_c) begin
            tmo_nx = TW'(1);
            case (state)
                S_DATA: begin
                    shreg_nx = {bit_c, shreg[7:1]};
                    bcnt_nx  = bcnt + 3'd1;
                    if (bcnt == 3'd7) begin
                        state_nx = S_PAR;
                    end
                end
                S_PAR: begin
                    par_nx   = bit_c;
                    state_nx = S_STOP;
                end
                default: begin
                    // Parity is judged before the stop bit so it wins when both are bad
                    if (^{shreg, par_q} == 1'b0) begin
                        perr_nx = 1'b1;
                    end else if (!bit_c) begin
                        ferr_nx = 1'b1;
                    end else begin
                        push_c = 1'b1;
                    end
                    state_nx = S_IDLE;
                    tmo_nx   = '0;
                end
            endcase
        end else if (tmo == TW'(TIMEOUT_CYC - 1)) begin
            ferr_nx  = 1'b1;
            state_nx = S_IDLE;
            tmo_nx   = '0;
        end else begin
            tmo_nx = tmo + TW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= S_IDLE;
            shreg     <= '0;
            bcnt      <= '0;
            par_q     <= 1'b0;
            tmo       <= '0;
            par_err_o <= 1'b0;
            frm_err_o <= 1'b0;
        end else begin
            state     <= state_nx;
            shreg     <= shreg_nx;
            bcnt      <= bcnt_nx;
            par_q     <= par_nx;
            tmo       <= tmo_nx;
            par_err_o <= perr_nx;
            frm_err_o <= ferr_nx;
        end
    end

    // Scan-code FIFO; head byte is precomputed so dat_o is a plain register
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr, wptr_nx, rptr_nx;
    logic [CW-1:0] cnt_nx, left_c;
    logic [7:0]    head_nx;
    logic          ovf_nx, pop_c, full_c, wr_c;

    always_comb begin
        pop_c   = rd_i & vld_o;
        full_c  = (cnt_o == CW'(FIFO_DEPTH));
        wr_c    = 1'b0;
        wptr_nx = wptr;
        rptr_nx = rptr;
        cnt_nx  = cnt_o;
        ovf_nx  = ovf_o;
        left_c  = cnt_o - CW'(pop_c);
        if (clr_i) begin
            wptr_nx = '0;
            rptr_nx = '0;
            cnt_nx  = '0;
            ovf_nx  = 1'b0;
        end else begin
            // A full FIFO still accepts a push when it is popped in the same cycle
            wr_c = push_c & (~full_c | pop_c);
            if (wr_c) begin
                wptr_nx = wptr + AW'(1);
            end
            if (pop_c) begin
                rptr_nx = rptr + AW'(1);
            end
            cnt_nx = cnt_o + CW'(wr_c) - CW'(pop_c);
            if (push_c && full_c && !pop_c) begin
                ovf_nx = 1'b1;
            end
        end
        if (cnt_nx == '0) begin
            head_nx = 8'h00;
        end else if (left_c == '0) begin
            head_nx = shreg;
        end else begin
            head_nx = mem[rptr_nx];
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_c) begin
            mem[wptr] <= shreg;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr  <= '0;
            rptr  <= '0;
            cnt_o <= '0;
            ovf_o <= 1'b0;
            dat_o <= 8'h00;
            vld_o <= 1'b0;
            irq_o <= 1'b0;
        end else begin
            wptr  <= wptr_nx;
            rptr  <= rptr_nx;
            cnt_o <= cnt_nx;
            ovf_o <= ovf_nx;
            dat_o <= head_nx;
            vld_o <= (cnt_nx != '0);
            irq_o <= (cnt_nx != '0) | ovf_nx;
        end
    end

endmodule

// File: tb/tb_ps2_rx_core.sv
// tb_ps2_rx_core: scoreboard bench for ps2_rx_core.
// Stimulus predicts each frame's outcome into queues. A monitor compares popped
// bytes and error pulses against those queues.
module tb_ps2_rx_core;

    localparam int unsigned FIFO_DEPTH  = 8;
    localparam int unsigned FILT_LEN    = 4;
    localparam int unsigned TIMEOUT_CYC = 2400;
    localparam int unsigned HALF        = 20;           // PS/2 half-bit period in clk_i cycles
    localparam int unsigned LAT_FALL    = 2 + FILT_LEN; // pad fall -> internal fall cycle

    logic       clk_i = 1'b0;
    logic       rst_i, en_i, ps2_clk_i, ps2_dat_i, rd_i, clr_i;
    logic [7:0] dat_o;
    logic [3:0] cnt_o;
    logic       vld_o, par_err_o, frm_err_o, ovf_o, irq_o;

    ps2_rx_core #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .FILT_LEN   (FILT_LEN),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .en_i     (en_i),
        .ps2_clk_i(ps2_clk_i),
        .ps2_dat_i(ps2_dat_i),
        .rd_i     (rd_i),
        .clr_i    (clr_i),
        .dat_o    (dat_o),
        .vld_o    (vld_o),
        .cnt_o    (cnt_o),
        .par_err_o(par_err_o),
        .frm_err_o(frm_err_o),
        .ovf_o    (ovf_o),
        .irq_o    (irq_o)
    );

    always #5 clk_i = ~clk_i;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q[$];
    int         err_q[$];   // 1 = parity error, 2 = framing error
    logic       exp_ovf = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: sample just after the falling edge, when rd_i is settled for the next edge
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk_i);
            #1;
            if (!rst_i) begin
                if (rd_i && vld_o) begin
                    if (exp_q.size() == 0) begin
                        check("pop_unexpected", 32'(dat_o), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("pop_data", 32'(dat_o), 32'(e));
                    end
                end
                if (par_err_o || frm_err_o) begin
                    if (err_q.size() == 0) begin
                        check("err_unexpected", 32'({frm_err_o, par_err_o}), 32'd0);
                    end else begin
                        check("err_kind", 32'({frm_err_o, par_err_o}), 32'(err_q.pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // Predict the decoder's view of a frame; a long glitch duplicates bit gi
    task automatic predict(input logic [10:0] f, input int gi, input int glen, input bit pop_same);
        logic [10:0] r;
        logic [7:0]  b;
        for (int k = 0; k < 11; k++) begin
            if (gi >= 0 && glen >= int'(FILT_LEN) && k > gi) r[k] = f[k-1];
            else                                             r[k] = f[k];
        end
        b = r[8:1];
        if (^{b, r[9]} == 1'b0)                                   err_q.push_back(1);
        else if (!r[10])                                         err_q.push_back(2);
        else if (exp_q.size() >= FIFO_DEPTH && !pop_same)        exp_ovf = 1'b1;
        else                                                     exp_q.push_back(b);
    endtask

    // mode 1: check push latency for 0x1C; mode 2: pop in the push cycle
    task automatic send_bit(input logic b, input int glen, input int mode);
        ps2_dat_i = b;
        if (glen > 0) begin
            repeat (5) @(negedge clk_i);
            ps2_clk_i = 1'b0;
            repeat (glen) @(negedge clk_i);
            ps2_clk_i = 1'b1;
            repeat (HALF - 5 - glen) @(negedge clk_i);
        end else begin
            repeat (HALF) @(negedge clk_i);
        end
        ps2_clk_i = 1'b0;
        for (int j = 1; j <= int'(HALF); j++) begin
            @(negedge clk_i);
            if (mode == 1 && j == int'(LAT_FALL)) check("lat_pre_vld", 32'(vld_o), 32'd0);
            if (mode == 1 && j == int'(LAT_FALL) + 1) begin
                check("lat_vld", 32'(vld_o), 32'd1);
                check("lat_dat", 32'(dat_o), 32'h1C);
                check("lat_cnt", 32'(cnt_o), 32'd1);
                check("lat_errs", 32'({par_err_o, frm_err_o}), 32'd0);
            end
            if (mode == 2 && j == int'(LAT_FALL))     rd_i = 1'b1;
            if (mode == 2 && j == int'(LAT_FALL) + 1) rd_i = 1'b0;
        end
        ps2_clk_i = 1'b1;
    endtask

    function automatic logic [10:0] mkframe(input logic [7:0] b, input logic pflip, input logic stop);
        return {stop, ~^b ^ pflip, b, 1'b0};
    endfunction

    task automatic send_frame(input logic [10:0] f, input int gi, input int glen, input int mode);
        for (int i = 0; i < 11; i++) begin
            send_bit(f[i], (i == gi) ? glen : 0, (i == 10) ? mode : 0);
        end
        ps2_dat_i = 1'b1;
        repeat (HALF) @(negedge clk_i);
    endtask

    task automatic frame(input logic [7:0] b, input logic pflip, input logic stop, input int gi,
                         input int glen, input int mode);
        logic [10:0] f;
        f = mkframe(b, pflip, stop);
        predict(f, gi, glen, mode == 2);
        send_frame(f, gi, glen, mode);
    endtask

    task automatic pop_n(input int n);
        rd_i = 1'b1;
        repeat (n) @(negedge clk_i);
        rd_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic check_state(input string tag);
        int n;
        n = exp_q.size();
        check({tag, "_cnt"}, 32'(cnt_o), 32'(n));
        check({tag, "_vld"}, 32'(vld_o), 32'(n != 0));
        check({tag, "_ovf"}, 32'(ovf_o), 32'(exp_ovf));
        check({tag, "_irq"}, 32'(irq_o), 32'((n != 0) || exp_ovf));
        check({tag, "_dat"}, 32'(dat_o), (n != 0) ? 32'(exp_q[0]) : 32'd0);
    endtask

    initial begin
        logic [10:0] f;
        rst_i = 1'b1; en_i = 1'b1; ps2_clk_i = 1'b1; ps2_dat_i = 1'b1; rd_i = 1'b0; clr_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check("rst_outs", 32'({dat_o, vld_o, cnt_o, par_err_o, frm_err_o, ovf_o, irq_o}), 32'd0);
        rst_i = 1'b0;
        repeat (5) @(negedge clk_i);

        // Good frame 0x1C with latency checks, then pop it
        frame(8'h1C, 1'b0, 1'b1, -1, 0, 1);
        check_state("good1");
        pop_n(1);
        check_state("good1_pop");

        // Parity error, then bad stop bit
        frame(8'h1C, 1'b1, 1'b1, -1, 0, 0);
        check_state("perr");
        frame(8'h1C, 1'b0, 1'b0, -1, 0, 0);
        check_state("ferr");

        // Nine frames without pops: last one overflows
        for (int i = 0; i < 9; i++) frame(8'(8'h41 + i), 1'b0, 1'b1, -1, 0, 0);
        check_state("full");
        check("full_dat41", 32'(dat_o), 32'h41);
        pop_n(8);
        check_state("drained");
        clr_i = 1'b1;
        @(negedge clk_i);
        clr_i = 1'b0;
        exp_q.delete();
        exp_ovf = 1'b0;
        check_state("clr");

        // Full FIFO with a pop in the cycle of the ninth push
        for (int i = 0; i < 8; i++) frame(8'(8'h61 + i), 1'b0, 1'b1, -1, 0, 0);
        frame(8'h69, 1'b0, 1'b1, -1, 0, 2);
        check_state("pushpop");
        pop_n(8);
        check_state("pushpop_drain");

        // Short clock glitch ignored; long glitch adds a bit (decodes as 0x38, stop=0)
        frame(8'h1C, 1'b0, 1'b1, 3, int'(FILT_LEN) - 1, 0);
        check_state("glitch_short");
        pop_n(1);
        frame(8'h1C, 1'b0, 1'b1, 1, int'(FILT_LEN) + 2, 0);
        check_state("glitch_long");

        // Timeout after four data bits
        f = mkframe(8'h33, 1'b0, 1'b1);
        err_q.push_back(2);
        for (int i = 0; i < 4; i++) send_bit(f[i], 0, 0);
        ps2_dat_i = f[4];
        repeat (HALF) @(negedge clk_i);
        ps2_clk_i = 1'b0;
        for (int j = 1; j <= int'(LAT_FALL + TIMEOUT_CYC); j++) begin
            @(negedge clk_i);
            if (j == int'(HALF)) begin
                ps2_clk_i = 1'b1;
                ps2_dat_i = 1'b1;
            end
            if (j == int'(LAT_FALL + TIMEOUT_CYC) - 1) check("tmo_early", 32'(frm_err_o), 32'd0);
            if (j == int'(LAT_FALL + TIMEOUT_CYC))     check("tmo_pulse", 32'(frm_err_o), 32'd1);
        end
        repeat (HALF) @(negedge clk_i);
        frame(8'h5A, 1'b0, 1'b1, -1, 0, 0);
        check_state("after_tmo");
        pop_n(1);

        // Disabled receiver ignores a full frame
        en_i = 1'b0;
        send_frame(mkframe(8'h77, 1'b0, 1'b1), -1, 0, 0);
        en_i = 1'b1;
        repeat (4) @(negedge clk_i);
        check_state("disabled");

        check("err_left", 32'(err_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
